// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a synchronous 1-cycle ROM.
// Owns the fetch PC and issues one ROM read per cycle when there is room.
// Each returned word is tagged with its PC and buffered in a small FIFO.
// A redirect flushes the FIFO and drops any ROM read still in flight.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_en_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_inst_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_pc_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic          push;
    logic          pop;
    logic          issue;
    logic [CW:0]   occ;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // FIFO head and ROM address are pure functions of registered state.
    always_comb begin
        inst_valid_o = (count_q != '0);
        inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : '0;
        inst_pc_o    = inst_valid_o ? fifo_pc_q[rd_ptr_q]   : '0;
        rom_addr_o   = pc_q[ADDR_W+1:2];
    end

    // Handshake and issue decision; the in-flight read reserves a FIFO slot.
    always_comb begin
        pop   = inst_valid_o & inst_ready_i & ~redirect_valid_i;
        push  = inflight_q & ~redirect_valid_i;
        occ   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue = fetch_en_i & ~redirect_valid_i & (occ < (CW+1)'(DEPTH));
    end

    // Next-state for PC, in-flight tracking and FIFO bookkeeping.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect_valid_i) begin
            pc_d     = redirect_pc_i & ~32'h3;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC_ALIGNED;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only visible through count, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            fifo_inst_q[wr_ptr_q] <= rom_inst_i;
            fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule
